// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv
// Description : RV32M multiply/divide unit, radix-2 shift-add / restoring
//               divide, fixed 33-cycle latency from accepted start to md_done.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               md_start,
  input  logic [2:0]         md_op,
  input  logic [REG_LEN-1:0] md_in1,
  input  logic [REG_LEN-1:0] md_in2,
  output logic               md_busy,
  output logic               md_done,
  output logic [REG_LEN-1:0] md_out
);

  localparam int c_CW = $clog2(REG_LEN);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(REG_LEN - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [c_CW-1:0]    r_cnt;
  logic [2:0]         r_op;
  logic [REG_LEN-1:0] r_opd;
  logic [REG_LEN-1:0] r_hi;
  logic [REG_LEN-1:0] r_lo;
  logic [REG_LEN-1:0] r_out;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;

  // Operand sign handling at acceptance: datapath always works on magnitudes.
  logic               w_sgn1;
  logic               w_sgn2;
  logic               w_neg1;
  logic               w_neg2;
  logic [REG_LEN-1:0] w_mag1;
  logic [REG_LEN-1:0] w_mag2;

  assign w_sgn1 = (md_op == 3'b001) || (md_op == 3'b010) ||
                  (md_op == 3'b100) || (md_op == 3'b110);
  assign w_sgn2 = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
  assign w_neg1 = w_sgn1 & md_in1[REG_LEN-1];
  assign w_neg2 = w_sgn2 & md_in2[REG_LEN-1];
  assign w_mag1 = w_neg1 ? -md_in1 : md_in1;
  assign w_mag2 = w_neg2 ? -md_in2 : md_in2;

  // Multiply step: r_hi:r_lo is the partial product, multiplier shifts out of r_lo.
  logic [REG_LEN:0]   w_madd;
  logic [REG_LEN-1:0] w_mhi;
  logic [REG_LEN-1:0] w_mlo;

  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_mhi  = w_madd[REG_LEN:1];
  assign w_mlo  = {w_madd[0], r_lo[REG_LEN-1:1]};

  // Divide step: r_hi is the partial remainder, quotient bits shift into r_lo.
  logic [REG_LEN:0]   w_shift;
  logic [REG_LEN:0]   w_sub;
  logic               w_ge;
  logic [REG_LEN-1:0] w_dhi;
  logic [REG_LEN-1:0] w_dlo;

  assign w_shift = {r_hi, r_lo[REG_LEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_opd};
  assign w_sub   = w_shift - {1'b0, r_opd};
  assign w_dhi   = w_ge ? w_sub[REG_LEN-1:0] : w_shift[REG_LEN-1:0];
  assign w_dlo   = {r_lo[REG_LEN-2:0], w_ge};

  logic [REG_LEN-1:0]   w_hi_nxt;
  logic [REG_LEN-1:0]   w_lo_nxt;
  logic [2*REG_LEN-1:0] w_prod;
  logic [2*REG_LEN-1:0] w_sprod;
  logic [REG_LEN-1:0]   w_quo;
  logic [REG_LEN-1:0]   w_rem;
  logic [REG_LEN-1:0]   w_res;

  assign w_hi_nxt = r_op[2] ? w_dhi : w_mhi;
  assign w_lo_nxt = r_op[2] ? w_dlo : w_mlo;
  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_sprod  = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;

  // Divide by zero yields an all-ones magnitude quotient; signed DIV must not negate it.
  always_comb begin
    w_res = '0;
    case (r_op)
      3'b000:                 w_res = w_sprod[REG_LEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_sprod[2*REG_LEN-1:REG_LEN];
      3'b100:                 w_res = r_dz ? '1 : w_quo;
      3'b101:                 w_res = w_lo_nxt;
      3'b110:                 w_res = w_rem;
      default:                w_res = w_hi_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_opd   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_out   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (md_start) begin
            r_op    <= md_op;
            r_opd   <= md_op[2] ? w_mag2 : w_mag1;
            r_hi    <= '0;
            r_lo    <= md_op[2] ? w_mag1 : w_mag2;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_dz    <= (md_in2 == '0);
            r_cnt   <= '0;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + c_CW'(1);
          if (r_cnt == c_LAST) begin
            r_out   <= w_res;
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign md_busy = (r_state != c_IDLE);
  assign md_done = (r_state == c_DONE);
  assign md_out  = r_out;

endmodule
`default_nettype wire

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port md_start, input, 1 bit: request a new operation; sampled only when md_busy=0.
REQ-004 SHALL have port md_op, input, 3 bits: RV32M funct3, encoded as 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port md_in1, input, REG_LEN (32) bits: multiplicand or dividend.
REQ-006 SHALL have port md_in2, input, REG_LEN (32) bits: multiplier or divisor.
REQ-007 SHALL have port md_busy, output, 1 bit: operation in flight, new requests ignored.
REQ-008 SHALL have port md_done, output, 1 bit: one-cycle pulse marking md_out valid.
REQ-009 SHALL have port md_out, output, REG_LEN bits: result, held until the next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and DONE.
REQ-011 SHALL transition IDLE->CALC on a clock edge with md_start=1.
- On that transition: latch md_op, md_in1 and md_in2.
- Clear the iteration counter to 0.
REQ-012 SHALL ignore md_in1, md_in2 and md_op changes after acceptance, with the result depending only on the latched values.
REQ-013 SHALL stay in CALC for exactly 32 cycles with one iteration per cycle.
- Multiply: shift-add, radix-2.
- Divide: restoring, radix-2.
- The counter runs 0..31; at counter=31 the FSM moves to DONE.
REQ-014 SHALL hold DONE for exactly one cycle, then return to IDLE.
REQ-015 SHALL have fixed latency: start sampled in cycle 0, CALC in cycles 1-32, md_done=1 and md_out valid in cycle 33, independent of operand values and special cases.
REQ-016 SHALL drive md_busy=1 in CALC and DONE and md_busy=0 in IDLE, so md_start in CALC or DONE is ignored.
REQ-017 SHALL accept md_start held high continuously on the first IDLE cycle after DONE, giving back-to-back operations every 34 cycles.
REQ-018 SHALL update md_out only on the CALC->DONE edge, holding it stable through IDLE until the next result.
REQ-019 SHALL produce for MUL the low 32 bits of the 64-bit product.
REQ-020 SHALL produce for MULH the high 32 bits of signed x signed.
REQ-021 SHALL produce for MULHSU the high 32 bits of signed md_in1 x unsigned md_in2.
REQ-022 SHALL produce for MULHU the high 32 bits of unsigned x unsigned.
REQ-023 SHALL compute signed ops on magnitudes, then correct signs.
- Product is negative iff the operand signs differ.
- Quotient is negative iff the operand signs differ.
- Remainder takes the sign of the dividend.
- Division truncates toward zero.
REQ-024 SHALL handle divide by zero (divisor=0):
- DIV/DIVU return 0xFFFFFFFF.
- REM/REMU return the dividend.
REQ-025 SHALL handle signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF):
- DIV returns 0x80000000.
- REM returns 0.
REQ-026 SHALL keep the full 33-cycle latency in the special cases of REQ-024 and REQ-025.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set state IDLE, counter 0, md_busy=0, md_done=0, md_out=0.
REQ-028 SHALL give rst priority over md_start, discarding any in-flight operation with no md_done pulse.
REQ-029 SHALL accept md_start on the first edge with rst=0.

Verification
REQ-030 SHALL cover: DIVU 100/7 -> md_out=0x0000000E in cycle 33, md_done high exactly 1 cycle; REMU 100/7 -> 0x00000002.
REQ-031 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-032 SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all in cycle 33.
REQ-033 SHALL cover: operands 0xFFFFFFFF, 0xFFFFFFFF -> MUL 0x00000001, MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE.
REQ-034 SHALL cover: rst=1 in cycle 10 of CALC -> md_busy=0, md_done=0, md_out=0 next cycle, no later md_done.
REQ-035 SHALL cover: md_start held high with operands changed mid-CALC -> result uses latched operands; next operation accepted in cycle 34, its md_done in cycle 67.
